// File: rtl/csr_rmw_pkg.sv
// csr_rmw_pkg: shared operation encodings, controller state enum and the
// wait-phase timeout limit for the CSR read-modify-write controller.
package csr_rmw_pkg;

   // CSR operation as presented by the execute stage
   typedef enum logic [1:0] {
      OP_RSV = 2'b00,
      OP_RW  = 2'b01,
      OP_RS  = 2'b10,
      OP_RC  = 2'b11
   } csr_op_e;

   // Controller sequence: read, optional write, then hold the response
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      WR_WAIT  = 3'd4,
      RESP     = 3'd5
   } csr_state_e;

   // Cycles a wait phase may spend without the CSR file showing busy
   localparam int TIMEOUT_CYCLES = 16;
   localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combines the old CSR value with the operand.
// RW replaces, RS sets bits, RC clears bits; no carries anywhere.
module csr_rmw_alu
   import csr_rmw_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  csr_op_e          op,
   input  logic [WIDTH-1:0] old_val,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] new_val
);

   // Bitwise combine; the reserved op is never written so its value is moot
   always_comb begin
      new_val = operand;
      case (op)
         OP_RS:   new_val = old_val | operand;
         OP_RC:   new_val = old_val & ~operand;
         default: new_val = operand;
      endcase
   end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// csr_rmw_ctrl: sequences one CSR read-modify-write per request.
// Reads the CSR, checks existence/read-only, optionally writes the combined
// value back, then holds the old value on the response until accepted.
// Optional: define CSR_RMW_TIMEOUT_EN to abort a wait phase with an error
// when the CSR file never shows busy within TIMEOUT_CYCLES cycles.
module csr_rmw_ctrl
   import csr_rmw_pkg::*;
#(
   parameter int CSR_DATA_WIDTH = 32,
   parameter int CSR_ADDR_WIDTH = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [1:0]                req_op_i,
   input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [CSR_DATA_WIDTH-1:0] req_wdata_i,
   input  logic                      req_nowr_i,
   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [CSR_DATA_WIDTH-1:0] resp_rdata_o,
   output logic                      resp_err_o,
   output logic                      csr_en_o,
   output logic                      csr_we_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
   output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
   input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
   input  logic                      csr_busy_i,
   input  logic                      csr_exists_i,
   input  logic                      csr_ro_i
);

   csr_state_e                state_q, state_d;
   csr_op_e                   op_q;
   logic [CSR_ADDR_WIDTH-1:0] addr_q;
   logic [CSR_DATA_WIDTH-1:0] wdata_q, old_q, new_val;
   logic                      nowr_q, err_q, seen_hi_q, live_q;
   logic                      accept, in_wait, rd_done, wr_done;
   logic                      wr_needed, rd_err, tmo_hit;

   assign accept    = req_valid_i && req_ready_o;
   assign in_wait   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   // a wait phase completes on the first low cycle after busy was seen high
   assign rd_done   = (state_q == RD_WAIT) && seen_hi_q && !csr_busy_i;
   assign wr_done   = (state_q == WR_WAIT) && seen_hi_q && !csr_busy_i;
   // RS/RC with a zero source must not write (and so may hit read-only CSRs)
   assign wr_needed = (op_q == OP_RW) || !nowr_q;
   assign rd_err    = !csr_exists_i || (op_q == OP_RSV) || (csr_ro_i && wr_needed);

   csr_rmw_alu #(.WIDTH(CSR_DATA_WIDTH)) u_alu (
      .op      (op_q),
      .old_val (old_q),
      .operand (wdata_q),
      .new_val (new_val)
   );

`ifdef CSR_RMW_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_cnt_q;

   // Count quiet cycles in a wait phase until the CSR file shows busy
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         tmo_cnt_q <= '0;
      else if (in_wait && !seen_hi_q && !csr_busy_i)
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else
         tmo_cnt_q <= '0;
   end

   assign tmo_hit = in_wait && !seen_hi_q && !csr_busy_i &&
                    (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = RD_ISSUE;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (tmo_hit)
               state_d = RESP;
            else if (rd_done)
               state_d = (rd_err || !wr_needed) ? RESP : WR_ISSUE;
         end
         WR_ISSUE: state_d = WR_WAIT;
         WR_WAIT:  if (tmo_hit || wr_done) state_d = RESP;
         RESP:     if (resp_ready_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; everything idles at zero
   always_comb begin
      req_ready_o  = 1'b0;
      csr_en_o     = 1'b0;
      csr_we_o     = 1'b0;
      csr_addr_o   = '0;
      csr_data_o   = '0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      resp_rdata_o = '0;
      case (state_q)
         IDLE:     req_ready_o = live_q;
         RD_ISSUE: begin
            csr_en_o   = 1'b1;
            csr_addr_o = addr_q;
         end
         WR_ISSUE: begin
            csr_en_o   = 1'b1;
            csr_we_o   = 1'b1;
            csr_addr_o = addr_q;
            csr_data_o = new_val;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            resp_rdata_o = err_q ? '0 : old_q;
         end
         default: ;
      endcase
   end

   // Ready comes up on the first edge after reset is released
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) live_q <= 1'b0;
      else          live_q <= 1'b1;
   end

   // Track busy-high within the current wait phase
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     seen_hi_q <= 1'b0;
      else if (in_wait) seen_hi_q <= seen_hi_q | csr_busy_i;
      else              seen_hi_q <= 1'b0;
   end

   // Request latch, read capture and error flag
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         op_q    <= OP_RSV;
         addr_q  <= '0;
         wdata_q <= '0;
         nowr_q  <= 1'b0;
         old_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= csr_op_e'(req_op_i);
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            nowr_q  <= req_nowr_i;
            old_q   <= '0;
            err_q   <= 1'b0;
         end
         if (rd_done) begin
            old_q <= csr_data_i;
            err_q <= rd_err;
         end
         if (tmo_hit) err_q <= 1'b1;
      end
   end

endmodule
